// File: rtl/ysyx_23060229_lsu_pkg.sv
// Shared encodings for the load/store unit.
//   Access sizes (req_size), AXI response codes, LSU FSM states, and a helper
//   that classifies an AXI response as an error.
package ysyx_23060229_lsu_pkg;

    localparam logic [1:0] SzByte    = 2'd0;
    localparam logic [1:0] SzHalf    = 2'd1;
    localparam logic [1:0] SzWord    = 2'd2;
    localparam logic [1:0] SzIllegal = 2'd3;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdD,
        StWr,
        StWrB,
        StResp
    } lsu_state_e;

    // Anything other than OKAY (including EXOKAY, unused on AXI-Lite) is an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RespOkay;
    endfunction

endpackage

// File: rtl/ysyx_23060229_lsu_align.sv
// Combinational data alignment for the LSU.
//   req_size/req_off/req_wdata : incoming request, used for error detection and
//                                store lane/strobe generation
//   req_err                    : illegal size, or misaligned when MISALIGN_ERR=1
//   req_off_al                 : byte offset forced down to natural alignment
//   st_wdata/st_wstrb          : replicated store data and byte strobes
//   ld_size/ld_off/bus_rdata   : latched load request and raw bus read data
//   ld_rdata                   : load data shifted to bit 0, zero-extended
module ysyx_23060229_lsu_align
    import ysyx_23060229_lsu_pkg::*;
#(
    parameter bit MISALIGN_ERR = 1'b1
) (
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic        req_err,
    output logic [1:0]  req_off_al,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ld_rdata
);

    logic        misalign;
    logic [31:0] shifted;

    always_comb begin
        misalign = ((req_size == SzHalf) && req_off[0]) ||
                   ((req_size == SzWord) && (req_off != 2'b00));
        req_err  = (req_size == SzIllegal) || (MISALIGN_ERR && misalign);

        // Only matters when misaligned accesses are silently aligned.
        req_off_al = req_off;
        if (req_size == SzHalf) begin
            req_off_al = {req_off[1], 1'b0};
        end else if (req_size == SzWord) begin
            req_off_al = 2'b00;
        end

        unique case (req_size)
            SzByte: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_off_al;
            end
            SzHalf: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = 4'b0011 << req_off_al;
            end
            default: begin
                st_wdata = req_wdata;
                st_wstrb = 4'b1111;
            end
        endcase

        shifted = bus_rdata >> {ld_off, 3'b000};
        unique case (ld_size)
            SzByte:  ld_rdata = {24'd0, shifted[7:0]};
            SzHalf:  ld_rdata = {16'd0, shifted[15:0]};
            default: ld_rdata = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_23060229_lsu.sv
// Load/store unit: one request at a time, executed on an AXI4-Lite master.
//   req_*   : request from execute (valid/ready, we, size, addr, wdata)
//   resp_*  : response to execute (valid/ready, rdata zero-extended, err)
//   ar*/r*  : AXI-Lite read address / read data channels
//   aw*/w*/b*: AXI-Lite write address / write data / write response channels
// All handshake outputs decode from the state register and aw/w done flags,
// so there is no combinational path from AXI inputs to AXI outputs.
module ysyx_23060229_lsu
    import ysyx_23060229_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter bit          MISALIGN_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,

    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    lsu_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done_q;
    logic              w_done_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              req_err;
    logic [1:0]        req_off_al;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wstrb;
    logic [31:0]       ld_rdata;

    ysyx_23060229_lsu_align #(
        .MISALIGN_ERR (MISALIGN_ERR)
    ) u_align (
        .req_size   (req_size),
        .req_off    (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .req_err    (req_err),
        .req_off_al (req_off_al),
        .st_wdata   (st_wdata),
        .st_wstrb   (st_wstrb),
        .ld_size    (size_q),
        .ld_off     (addr_q[1:0]),
        .bus_rdata  (rdata),
        .ld_rdata   (ld_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            size_q    <= SzByte;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q    <= {req_addr[ADDR_W-1:2], req_off_al};
                        size_q    <= req_size;
                        wdata_q   <= st_wdata;
                        wstrb_q   <= st_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= req_err;
                        if (req_err) begin
                            state_q <= StResp;
                        end else if (req_we) begin
                            state_q <= StWr;
                        end else begin
                            state_q <= StRdA;
                        end
                    end
                end
                StRdA: begin
                    if (arready) begin
                        state_q <= StRdD;
                    end
                end
                StRdD: begin
                    if (rvalid) begin
                        err_q   <= resp_is_err(rresp);
                        rdata_q <= resp_is_err(rresp) ? 32'd0 : ld_rdata;
                        state_q <= StResp;
                    end
                end
                StWr: begin
                    // AW and W complete independently; leave once both have.
                    if ((aw_done_q || awready) && (w_done_q || wready)) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= StWrB;
                    end else begin
                        aw_done_q <= aw_done_q || awready;
                        w_done_q  <= w_done_q || wready;
                    end
                end
                StWrB: begin
                    if (bvalid) begin
                        err_q   <= resp_is_err(bresp);
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign araddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign arvalid = (state_q == StRdA);
    assign rready  = (state_q == StRdD);

    assign awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign awvalid = (state_q == StWr) && !aw_done_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = (state_q == StWr) && !w_done_q;
    assign bready  = (state_q == StWrB);

endmodule

// File: tb/tb_ysyx_23060229_lsu.sv
module tb_ysyx_23060229_lsu;
    import ysyx_23060229_lsu_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid, resp_ready, resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       rdata, wdata;
    logic [1:0]        rresp, bresp;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]        wstrb;

    ysyx_23060229_lsu #(
        .ADDR_W       (ADDR_W),
        .MISALIGN_ERR (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard entry: expected response plus the cycle resp_valid must rise.
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t expq[$];
    int   last_hs = -1;

    // Slave configuration and observation.
    int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = RespOkay, s_bresp = RespOkay;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_wait = 0;
    logic        r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
    int          ar_fires = 0, aw_fires = 0, w_fires = 0, arvalid_cycles = 0, aw_hold = 0;
    logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0, aw_first = '0;
    logic [3:0]  last_wstrb = '0;
    logic        aw_unstable = 0;

    // AXI-Lite slave: drives at negedge, records handshakes just after.
    initial begin
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            end else begin
                if (arvalid) begin
                    ar_cnt++;
                    arvalid_cycles++;
                end
                arready = arvalid && (ar_cnt > ar_delay);
                if (r_pend && r_wait > 0) begin
                    r_wait--;
                    rvalid = 0;
                end else if (r_pend) begin
                    rvalid = 1; rdata = s_rdata; rresp = s_rresp;
                end else begin
                    rvalid = 0;
                end
                if (awvalid) begin
                    if (aw_cnt == 0) aw_first = awaddr;
                    else if (awaddr !== aw_first) aw_unstable = 1;
                    aw_cnt++;
                end
                awready = awvalid && (aw_cnt > aw_delay);
                if (wvalid) w_cnt++;
                wready = wvalid && (w_cnt > w_delay);
                bvalid = b_pend;
                bresp  = s_bresp;
                #1;
                if (arvalid && arready) begin
                    ar_fires++; last_araddr = araddr; ar_cnt = 0;
                    r_pend = 1; r_wait = r_delay;
                end
                if (rvalid && rready) r_pend = 0;
                if (awvalid && awready) begin
                    aw_fires++; last_awaddr = awaddr; aw_hold = aw_cnt; aw_cnt = 0; aw_got = 1;
                end
                if (wvalid && wready) begin
                    w_fires++; last_wdata = wdata; last_wstrb = wstrb; w_cnt = 0; w_got = 1;
                end
                if (bvalid && bready) b_pend = 0;
                if (aw_got && w_got) begin
                    b_pend = 1; aw_got = 0; w_got = 0;
                end
            end
        end
    end

    // Response monitor: compares every presented response against the queue head.
    initial begin
        logic pending;
        pending = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pending = 0;
            end else begin
                if (resp_valid) begin
                    if (expq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL resp_unexpected: rdata %h err %0d with none expected",
                                 resp_rdata, resp_err);
                    end else begin
                        if (!pending) check("resp_cycle", cyc, expq[0].cyc);
                        check("resp_rdata", resp_rdata, expq[0].rdata);
                        check("resp_err", resp_err, expq[0].err);
                        check("req_ready_in_resp", req_ready, 0);
                        if (resp_ready) begin
                            void'(expq.pop_front());
                            last_hs = cyc;
                        end
                    end
                end
                pending = resp_valid && !resp_ready;
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, output int t);
        int n;
        n = 0;
        t = -1;
        @(negedge clk);
        req_valid = 1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL req_accept_timeout: req_ready low for %0d cycles", n);
        end else begin
            t = cyc;
            expq.push_back('{exp_rd, exp_err, t + lat});
        end
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("resp_drained", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, n, b_ar, b_aw, b_w, b_arv;
        req_valid = 0; req_we = 0; req_size = SzByte; req_addr = '0; req_wdata = '0;
        resp_ready = 1;
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        @(negedge clk);
        rst = 0;

        // SB to the top byte lane.
        b_aw = aw_fires; b_w = w_fires;
        send(1, SzByte, 32'h8000_0003, 32'h1234_56AB, 32'h0, 0, 3, t);
        wait_done();
        check("sb_awaddr", last_awaddr, 32'h8000_0000);
        check("sb_wdata", last_wdata, 32'hABAB_ABAB);
        check("sb_wstrb", last_wstrb, 4'b1000);
        check("sb_hs_count", (aw_fires - b_aw) * 16 + (w_fires - b_w), 17);

        // SH to the upper half.
        send(1, SzHalf, 32'h8000_0002, 32'h0000_CAFE, 32'h0, 0, 3, t);
        wait_done();
        check("sh_wdata", last_wdata, 32'hCAFE_CAFE);
        check("sh_wstrb", last_wstrb, 4'b1100);

        // Loads from one word: LH upper half, LBU byte 1.
        s_rdata = 32'hBEEF_1234;
        send(0, SzHalf, 32'h8000_0002, 32'h0, 32'h0000_BEEF, 0, 3, t);
        wait_done();
        check("lh_araddr", last_araddr, 32'h8000_0000);
        send(0, SzByte, 32'h8000_0001, 32'h0, 32'h0000_0012, 0, 3, t);
        wait_done();

        // Misaligned word and illegal size: immediate error, no read traffic.
        b_arv = arvalid_cycles;
        send(0, SzWord, 32'h8000_0001, 32'h0, 32'h0, 1, 1, t);
        wait_done();
        send(0, SzIllegal, 32'h8000_0000, 32'h0, 32'h0, 1, 1, t);
        wait_done();
        check("err_no_arvalid", arvalid_cycles - b_arv, 0);

        // SW with W ready at once and AW delayed by 3 cycles.
        aw_delay = 3;
        b_aw = aw_fires; b_w = w_fires; aw_unstable = 0;
        send(1, SzWord, 32'h8000_0008, 32'h1122_3344, 32'h0, 0, 6, t);
        wait_done();
        aw_delay = 0;
        check("sw_aw_hold", aw_hold, 4);
        check("sw_aw_stable", aw_unstable, 0);
        check("sw_w_count", w_fires - b_w, 1);
        check("sw_aw_count", aw_fires - b_aw, 1);
        check("sw_awaddr", last_awaddr, 32'h8000_0008);
        check("sw_wdata", last_wdata, 32'h1122_3344);
        check("sw_wstrb", last_wstrb, 4'b1111);

        // Bus errors on write and read responses.
        s_bresp = RespSlverr;
        send(1, SzWord, 32'h8000_0008, 32'h5555_5555, 32'h0, 1, 3, t);
        wait_done();
        s_bresp = RespOkay;
        s_rresp = RespDecerr;
        send(0, SzWord, 32'h8000_0004, 32'h0, 32'h0, 1, 3, t);
        wait_done();
        s_rresp = RespOkay;

        // Back-pressure on the response; a queued request must wait for the handshake.
        s_rdata = 32'h55AA_33CC;
        resp_ready = 0;
        send(0, SzWord, 32'h8000_000C, 32'h0, 32'h55AA_33CC, 0, 3, t);
        req_valid = 1; req_we = 0; req_size = SzByte; req_addr = 32'h8000_000E;
        n = 0;
        #1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("bp_resp_seen", resp_valid, 1);
        @(negedge clk);
        @(negedge clk);
        resp_ready = 1;
        send(0, SzByte, 32'h8000_000E, 32'h0, 32'h0000_00AA, 0, 3, t2);
        check("bp_accept_after_hs", t2, last_hs + 1);
        wait_done();

        // Reset in the middle of a read data phase.
        r_delay = 10;
        send(0, SzWord, 32'h8000_0010, 32'h0, 32'h0, 0, 3, t);
        @(negedge clk);
        #1;
        check("mid_rd_rready", rready, 1);
        #1;
        rst = 1;
        #1;
        check("rst_mid_arvalid", arvalid, 0);
        check("rst_mid_rready", rready, 0);
        check("rst_mid_resp_valid", resp_valid, 0);
        check("rst_mid_req_ready", req_ready, 1);
        expq.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        r_delay = 0;
        s_rdata = 32'hDEAD_BEEF;
        send(0, SzWord, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 0, 3, t);
        wait_done();
        check("post_rst_araddr", last_araddr, 32'h8000_0000);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
